// File: rtl/torrence_types.sv
// Shared type definitions for the torrence cache / memory subsystem.
package torrence_types;

    // Operation carried on the L2 request interface.
    typedef enum logic [1:0] {
        LOAD       = 2'b00,
        STORE      = 2'b01,
        CLFLUSH    = 2'b10,
        MO_UNKNOWN = 2'b11
    } memory_operation_e;

    // Responder FSM states.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_WAIT    = 2'b01,
        ST_RESPOND = 2'b10
    } l2_responder_state_e;

    // Don't-care encoding for unreachable FSM codes.
    localparam logic [1:0] ST_UNKNOWN = 2'bxx;

    // Largest supported responder latency, and the counter width that holds it.
    localparam int L2_MAX_LATENCY = 15;
    localparam int L2_LAT_CNT_W   = $clog2(L2_MAX_LATENCY + 1);

endpackage

// File: rtl/l2_backing_store.sv
// Word-addressed backing store for the L2 responder: synchronous write,
// combinational read, asynchronous clear of every word.
module l2_backing_store #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [XLEN-1:0]       wdata_i,
    output logic [XLEN-1:0]       rdata_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [XLEN-1:0] mem_q [DEPTH];

    // Write one word per enabled cycle; clear the whole array on reset.
    // NOTE: the array is reset because the model must read back zero after
    // reset, which forces flops instead of a RAM macro; drop the clear if
    // this is ever mapped to real SRAM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            // NOTE: sequential state uses non-blocking assignment so every
            // flop samples pre-edge values regardless of statement order.
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Combinational read of the addressed word.
    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/l2_responder.sv
// Responder end of the L2 request interface: captures one request, waits a
// fixed latency, then pulses l2_req_fulfilled for one cycle with load data.
module l2_responder
    import torrence_types::*;
#(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  l2_req_valid,
    input  memory_operation_e     l2_req_type,
    input  logic [ADDR_WIDTH-1:0] l2_req_address,
    input  logic [XLEN-1:0]       l2_req_wdata,
    output logic                  l2_req_fulfilled,
    output logic [XLEN-1:0]       l2_rdata,
    output logic                  protocol_error
);

    // Capture edge plus the RESPOND cycle account for two of the LATENCY
    // cycles; the counter covers the rest. Unused when LATENCY is 1.
    localparam logic [L2_LAT_CNT_W-1:0] CNT_LOAD =
        (LATENCY > 1) ? L2_LAT_CNT_W'(LATENCY - 2) : '0;

    l2_responder_state_e      state_q, state_d;
    logic [L2_LAT_CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    memory_operation_e        type_q, type_d;
    logic [XLEN-1:0]          wdata_q, wdata_d;
    logic                     perr_q, perr_d;

    logic                     mem_we;
    logic [XLEN-1:0]          mem_rdata;

    // Next-state logic: capture in IDLE, count down in WAIT, one-cycle RESPOND.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        type_d  = type_q;
        wdata_d = wdata_q;
        perr_d  = perr_q;
        case (state_q)
            ST_IDLE: begin
                if (l2_req_valid) begin
                    addr_d  = l2_req_address;
                    type_d  = l2_req_type;
                    wdata_d = l2_req_wdata;
                    perr_d  = perr_q | (l2_req_type == MO_UNKNOWN);
                    if (LATENCY == 1) begin
                        state_d = ST_RESPOND;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESPOND;
                end else begin
                    cnt_d = cnt_q - L2_LAT_CNT_W'(1);
                end
            end
            ST_RESPOND: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = l2_responder_state_e'(ST_UNKNOWN);
            end
        endcase
    end

    // State, counter, capture and sticky-error registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            type_q  <= LOAD;
            wdata_q <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            type_q  <= type_d;
            wdata_q <= wdata_d;
            perr_q  <= perr_d;
        end
    end

    // Stores commit on the edge that leaves RESPOND.
    assign mem_we = (state_q == ST_RESPOND) && (type_q == STORE);

    l2_backing_store #(
        .XLEN       (XLEN),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_store (
        .clk     (clk),
        .reset_n (reset_n),
        .we_i    (mem_we),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    // Moore outputs decoded from the RESPOND state.
    assign l2_req_fulfilled = (state_q == ST_RESPOND);
    assign l2_rdata         = (l2_req_fulfilled && type_q == LOAD) ? mem_rdata : '0;
    assign protocol_error   = perr_q;

endmodule

// File: doc/l2_responder.md
Name: l2_responder

Overview:
- Responder end of the L2 request interface driven by the cache controllers (`l2_req_valid` / `l2_req_type` in, `l2_req_fulfilled` out).
- Services one word per request from an internal word-addressed backing store after a programmable fixed latency.
- Acts as the L2/memory model behind the icache and dcache. The icache line fill holds valid high and consumes one word per fulfilled pulse.

Parameters:
- XLEN, 32, data word width in bits.
- ADDR_WIDTH, 8, word-address width; backing store depth is 2**ADDR_WIDTH words.
- LATENCY, 4, cycles from request capture to fulfilled pulse; legal range 1..15.

Ports:
- clk  input  1  clock.
- reset_n  input  1  asynchronous, active-low reset.
- l2_req_valid  input  1  request present; level, may stay high across consecutive words.
- l2_req_type  input  memory_operation_e  LOAD, STORE, CLFLUSH or MO_UNKNOWN.
- l2_req_address  input  ADDR_WIDTH  word address of the request.
- l2_req_wdata  input  XLEN  store data.
- l2_req_fulfilled  output  1  one-cycle completion pulse.
- l2_rdata  output  XLEN  load data; valid only while l2_req_fulfilled=1.
- protocol_error  output  1  sticky; set on MO_UNKNOWN capture.

Behaviour:
- Reset (reset_n=0, async):
  - State goes to ST_IDLE; latency counter=0.
  - Captured address, type and wdata registers cleared.
  - Outputs: l2_req_fulfilled=0, l2_rdata=0, protocol_error=0.
  - All backing-store words cleared to 0.
- States: ST_IDLE, ST_WAIT, ST_RESPOND.
- ST_IDLE:
  - If l2_req_valid=1, capture type, address and wdata at the edge.
  - If LATENCY==1, go to ST_RESPOND; else load counter with LATENCY-2 and go to ST_WAIT.
  - If l2_req_valid=0, stay in ST_IDLE.
- ST_WAIT:
  - Counter decrements each cycle.
  - When counter==0, go to ST_RESPOND.
  - Inputs are ignored; captured values are used.
- ST_RESPOND (Moore outputs, exactly one cycle):
  - l2_req_fulfilled=1.
  - LOAD: l2_rdata=mem[captured address].
  - STORE: mem[captured address] written with captured wdata at the exiting edge; l2_rdata=0.
  - CLFLUSH: no memory effect; pulse only.
  - MO_UNKNOWN: pulse only; protocol_error was already set at capture.
  - Next state is always ST_IDLE.
- Latency: valid sampled high in ST_IDLE at edge t gives l2_req_fulfilled high during cycle t+LATENCY.
- Back-to-back requests:
  - The mandatory ST_IDLE cycle after ST_RESPOND lets the requester advance its address on the fulfilled edge; the new address is sampled in ST_IDLE.
  - Per-word period is therefore LATENCY+1 cycles.
- Requester drops valid mid-transaction: the captured request still completes and pulses fulfilled; no abort.
- Reset mid-transaction: the request is discarded; a pending STORE is not written; no fulfilled pulse.
- Address width: captured address indexes the store directly; no wrap logic is needed (full range is legal).
- protocol_error clears only on reset.

Decomposition:
- memory_operation_e already lives in torrence_types.
- Add to torrence_types:
  - l2_responder_state_e (2-bit: ST_IDLE=00, ST_WAIT=01, ST_RESPOND=10, ST_UNKNOWN=xx).
  - L2_MAX_LATENCY=15 constant.
- One sub-module: l2_backing_store.
  - Synchronous write port, combinational read port.
  - Async active-low clear.
  - Parameters XLEN and ADDR_WIDTH.
- FSM, latency counter and capture registers stay in l2_responder.

Test Plan:
- Reset then LOAD addr 0x10, LATENCY=4 -> fulfilled pulses exactly 4 cycles after capture, for 1 cycle, with l2_rdata=0.
- STORE addr 0x3A wdata 0xDEADBEEF, then LOAD 0x3A -> second fulfilled shows l2_rdata=0xDEADBEEF.
- Icache-style fill: valid held high, address 0x20..0x23 advancing on each fulfilled, preloaded 0x1111_0000+i -> four pulses spaced LATENCY+1=5 cycles apart, data matching each word.
- LATENCY=1 build: LOAD 0x05 -> fulfilled in the cycle immediately after capture; back-to-back period is 2 cycles.
- Drive reset_n low 2 cycles into a STORE of 0xCAFE to 0x07 -> no fulfilled; after reset, LOAD 0x07 returns 0.
- MO_UNKNOWN request -> fulfilled pulses once, protocol_error rises and stays 1 through a following LOAD, clears only on reset_n=0.
